load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 146 ++++++++++++++
 tb/tb_load_store_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: one transaction at a time, issued as 1/2/4 little-endian byte beats.
// Optional alignment checking is enabled with the LSU_ALIGN_CHECK_EN macro.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_write,
  input  logic [1:0]  access_type,
  input  logic        zext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [7:0]  m_wdata,
  input  logic        m_ack,
  input  logic [7:0]  m_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, zext_q, err_q;
  logic [1:0]  size_q, beat_idx, last_idx, next_idx;
  logic [31:0] wdata_q, load_buf, asm_val, load_val;
  logic        misaligned, is_upper, beat_fire, last_beat;

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = ((access_type == 2'b01) && addr[0]) ||
                      ((access_type == 2'b11) && (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign is_upper  = (access_type == 2'b10);
  assign beat_fire = m_req & m_ack;
  assign next_idx  = beat_idx + 2'd1;
  assign last_beat = (beat_idx == last_idx);

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = done & err_q;
  assign dbg_state = state_q;

  always_comb begin
    last_idx = 2'd3;
    case (size_q)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  // Merge the byte arriving this cycle, then extend according to access size.
  always_comb begin
    asm_val = load_buf;
    asm_val[{beat_idx, 3'b000} +: 8] = m_rdata;
    load_val = asm_val;
    case (size_q)
      2'b00:   load_val = zext_q ? {24'h0, asm_val[7:0]}  : {{24{asm_val[7]}}, asm_val[7:0]};
      2'b01:   load_val = zext_q ? {16'h0, asm_val[15:0]} : {{16{asm_val[15]}}, asm_val[15:0]};
      default: load_val = asm_val;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (is_upper || misaligned) ? S_DONE : S_ACCESS;
      end
      S_ACCESS: begin
        if (beat_fire && last_beat) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      zext_q   <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      beat_idx <= 2'd0;
      wdata_q  <= 32'h0;
      load_buf <= 32'h0;
      rdata    <= 32'h0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= 32'h0;
      m_wdata  <= 8'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            we_q     <= mem_write;
            zext_q   <= zext;
            size_q   <= access_type;
            wdata_q  <= wdata;
            beat_idx <= 2'd0;
            err_q    <= misaligned;
            if (is_upper) begin
              rdata <= {wdata[15:0], 16'h0};
            end else if (!misaligned) begin
              m_req   <= 1'b1;
              m_we    <= mem_write;
              m_addr  <= addr;
              m_wdata <= wdata[7:0];
            end
          end
        end
        S_ACCESS: begin
          if (beat_fire) begin
            load_buf <= asm_val;
            if (last_beat) begin
              m_req <= 1'b0;
              if (!we_q) rdata <= load_val;
            end else begin
              beat_idx <= next_idx;
              m_addr   <= m_addr + 32'd1;
              m_wdata  <= wdata_q[{next_idx, 3'b000} +: 8];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized traffic against a byte-memory reference model.
// Build with or without +define+LSU_ALIGN_CHECK_EN; expectations follow the same macro.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  access_type = 2'b00;
  logic        zext = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, err, m_req, m_we;
  logic [31:0] rdata, m_addr;
  logic [7:0]  m_wdata;
  logic        m_ack = 1'b0;
  logic [7:0]  m_rdata = 8'h0;
  logic [1:0]  dbg_state;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_write(mem_write),
    .access_type(access_type), .zext(zext), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int ack_mode = 0;  // 0: always ack, 1: random ack, 2: two wait cycles per beat
  int wait_cnt = 0;
  int cur_n = 0;

  logic [31:0] exp_rdata_q[$];
  logic [0:0]  exp_err_q[$];
  logic [31:0] exp_baddr_q[$];
  logic [0:0]  exp_bwe_q[$];
  logic [7:0]  exp_bdata_q[$];

  logic [7:0]  mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] model_rdata = 32'h0;

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  // ---------------- memory responder + beat monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ack    = 1'b0;
      wait_cnt = 0;
    end else begin
      case (ack_mode)
        0: m_ack = 1'b1;
        1: m_ack = ($urandom_range(0, 2) != 0);
        default: begin
          if (m_req) begin
            if (wait_cnt == 2) begin m_ack = 1'b1; wait_cnt = 0; end
            else begin m_ack = 1'b0; wait_cnt++; end
          end else begin
            m_ack = 1'b0;
            wait_cnt = 0;
          end
        end
      endcase
      m_rdata = mem_rd(m_addr);
      if (m_req && m_ack) begin
        if (exp_baddr_q.size() == 0) begin
          chk("unexpected_beat", m_addr, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] ea;
          logic [0:0]  ew;
          logic [7:0]  ed;
          ea = exp_baddr_q.pop_front();
          ew = exp_bwe_q.pop_front();
          ed = exp_bdata_q.pop_front();
          chk("beat_addr", m_addr, ea);
          chk("beat_we", {31'h0, m_we}, {31'h0, ew});
          if (ew) chk("beat_wdata", {24'h0, m_wdata}, {24'h0, ed});
        end
        if (m_we) mem[m_addr] = m_wdata;
      end
    end
  end

  // ---------------- completion monitor ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_rdata_q.size() == 0) begin
        chk("unexpected_done", 32'h1, 32'h0);
      end else begin
        logic [31:0] er;
        logic [0:0]  ee;
        er = exp_rdata_q.pop_front();
        ee = exp_err_q.pop_front();
        chk("rdata", rdata, er);
        chk("err", {31'h0, err}, {31'h0, ee});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issues one request and records what the memory and the result should look like.
  task automatic send_start(input logic we, input logic [1:0] typ, input logic zx,
                            input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic mis;
    logic [31:0] v;
    n   = (typ == 2'b00) ? 1 : (typ == 2'b01) ? 2 : 4;
    mis = ALIGN_CHECK && (((typ == 2'b01) && a[0]) || ((typ == 2'b11) && (a[1:0] != 2'b00)));
    v   = 32'h0;
    if (typ == 2'b10) begin
      model_rdata = {wd[15:0], 16'h0};
      cur_n = 0;
    end else if (mis) begin
      cur_n = 0;
    end else begin
      cur_n = n;
      for (int i = 0; i < n; i++) begin
        logic [31:0] ba;
        logic [7:0]  wb;
        ba = a + i;
        wb = 8'((wd >> (8 * i)) & 32'hFF);
        exp_baddr_q.push_back(ba);
        exp_bwe_q.push_back(we);
        exp_bdata_q.push_back(wb);
        if (we) ref_mem[ba] = wb;
        else    v = v + (32'(ref_rd(ba)) << (8 * i));
      end
      if (!we) begin
        if (n == 1)      model_rdata = zx ? (v & 32'hFF)   : 32'($signed(v[7:0]));
        else if (n == 2) model_rdata = zx ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
        else             model_rdata = v;
      end
    end
    exp_rdata_q.push_back(model_rdata);
    exp_err_q.push_back(mis);

    @(negedge clk);
    start = 1'b1; mem_write = we; access_type = typ; zext = zx; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    start = 1'b0;
    mem_write = 1'($urandom); access_type = 2'($urandom); zext = 1'($urandom);
    addr = $urandom; wdata = $urandom;
  endtask

  // Waits for done; returns at the negedge where done is seen.
  task automatic wait_done(input string name, input bit chk_lat);
    int cyc;
    bit seen;
    int exp_lat;
    seen = 1'b0;
    cyc  = 0;
    exp_lat = (ack_mode == 2) ? cur_n * 3 + 1 : cur_n + 1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; cyc = i; break; end
    end
    chk({name, "_done_seen"}, {31'h0, seen}, 32'h1);
    if (chk_lat && seen) chk({name, "_latency"}, cyc, exp_lat);
  endtask

  task automatic do_txn(input string name, input logic we, input logic [1:0] typ,
                        input logic zx, input logic [31:0] a, input logic [31:0] wd,
                        input bit chk_lat);
    send_start(we, typ, zx, a, wd);
    wait_done(name, chk_lat);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    {31'h0, busy},  32'h0);
    chk("rst_done",    {31'h0, done},  32'h0);
    chk("rst_err",     {31'h0, err},   32'h0);
    chk("rst_rdata",   rdata,          32'h0);
    chk("rst_m_req",   {31'h0, m_req}, 32'h0);
    chk("rst_m_we",    {31'h0, m_we},  32'h0);
    chk("rst_m_addr",  m_addr,         32'h0);
    chk("rst_m_wdata", {24'h0, m_wdata}, 32'h0);
    rst_n = 1'b1;

    // Word store; first start right after reset release
    ack_mode = 0;
    do_txn("word_store", 1'b1, 2'b11, 1'b0, 32'h100, 32'hA1B2C3D4, 1'b1);

    // Byte loads with sign and zero extension
    mem[32'h7] = 8'h85; ref_mem[32'h7] = 8'h85;
    do_txn("byte_load_sx", 1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 1'b1);
    do_txn("byte_load_zx", 1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 1'b1);

    // Halfword load with two wait cycles on each beat
    mem[32'h10] = 8'h34; ref_mem[32'h10] = 8'h34;
    mem[32'h11] = 8'h92; ref_mem[32'h11] = 8'h92;
    ack_mode = 2;
    do_txn("half_load_wait", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b1);
    ack_mode = 0;

    // Upper immediate, no memory traffic
    do_txn("upper", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0000BEEF, 1'b1);

    // Misaligned word load
    do_txn("misaligned_word", 1'b0, 2'b11, 1'b0, 32'h102, 32'h0, 1'b1);

    // Start while done is high must be ignored
    start = 1'b1; mem_write = 1'b0; access_type = 2'b10; wdata = 32'h1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_in_done_ignored_busy", {31'h0, busy}, 32'h0);
    do_txn("after_done_start", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0000CAFE, 1'b1);

    // Address wrap-around
    do_txn("wrap_store", 1'b1, 2'b11, 1'b0, 32'hFFFF_FFFC, 32'h11223344, 1'b1);
    do_txn("wrap_load", 1'b0, 2'b01, 1'b1, 32'hFFFF_FFFE, 32'h0, 1'b1);

    // Randomized traffic
    for (int t = 0; t < 70; t++) begin
      logic [31:0] a;
      ack_mode = $urandom_range(0, 1);
      a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + $urandom_range(0, 3))
                                      : (32'h100 + $urandom_range(0, 15));
      do_txn("rand", 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, ack_mode == 0);
    end

    // Reset during the second beat of a word load
    ack_mode = 0;
    send_start(1'b0, 2'b11, 1'b0, 32'h104, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_req", {31'h0, m_req}, 32'h0);
    chk("midrst_busy",  {31'h0, busy},  32'h0);
    chk("midrst_rdata", rdata,          32'h0);
    exp_rdata_q.delete(); exp_err_q.delete();
    exp_baddr_q.delete(); exp_bwe_q.delete(); exp_bdata_q.delete();
    model_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", {31'h0, busy}, 32'h0);
    do_txn("post_rst_load", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 1'b1);

    repeat (5) @(negedge clk);
    chk("pending_done",  exp_rdata_q.size(), 32'h0);
    chk("pending_beats", exp_baddr_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
